// File: rtl/pc16.sv
// pc16 -- program counter with load, increment and synchronous clear.
//
// The next-state logic is built structurally from a small nand-derived
// gate library (defined below). Only the state register is behavioural.
//
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous, active-high reset (out = 0, wrap = 0)
//   in    in   WIDTH  load value (jump target)
//   load  in   1      next out = in
//   inc   in   1      next out = out + 1
//   clr   in   1      synchronous clear, next out = 0
//   out   out  WIDTH  current counter value (registered)
//   wrap  out  1      registered pulse, high for one cycle after out
//                     rolled over from all-ones to zero by an increment
//
// Priority at each rising edge: clr > load > inc > hold.

module pc16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             wrap
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] inc_sel;
  logic [WIDTH-1:0] load_sel;
  logic [WIDTH-1:0] next_out;
  logic             next_wrap;

  logic inc_carry;
  logic load_n;
  logic clr_n;
  logic keep_n;

  // Ripple incrementer: carry-in tied high, carry-out marks the all-ones case.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gate_half_adder u_ha (
      .a     (out[i]),
      .b     (carry[i]),
      .sum   (inc_val[i]),
      .carry (carry[i+1])
    );

    gate_mux u_inc_mux (
      .a   (out[i]),
      .b   (inc_val[i]),
      .sel (inc),
      .y   (inc_sel[i])
    );

    gate_mux u_load_mux (
      .a   (inc_sel[i]),
      .b   (in[i]),
      .sel (load),
      .y   (load_sel[i])
    );

    // Clear mux forces zero.
    gate_mux u_clr_mux (
      .a   (load_sel[i]),
      .b   (1'b0),
      .sel (clr),
      .y   (next_out[i])
    );
  end

  // wrap is set only when the increment path wins and the carry ripples out.
  gate_and u_wrap_inc (
    .a (carry[WIDTH]),
    .b (inc),
    .y (inc_carry)
  );

  gate_not u_load_n (
    .a (load),
    .y (load_n)
  );

  gate_not u_clr_n (
    .a (clr),
    .y (clr_n)
  );

  gate_and u_keep_n (
    .a (load_n),
    .b (clr_n),
    .y (keep_n)
  );

  gate_and u_wrap_final (
    .a (inc_carry),
    .b (keep_n),
    .y (next_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= '0;
      wrap <= 1'b0;
    end else begin
      out  <= next_out;
      wrap <= next_wrap;
    end
  end

endmodule

// gate_nand -- primitive of the gate library.
//   a, b in; y = ~(a & b)
module gate_nand (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

// gate_not -- inverter from one nand.
//   a in; y = ~a
module gate_not (
  input  logic a,
  output logic y
);
  gate_nand u_n (.a(a), .b(a), .y(y));
endmodule

// gate_and -- nand followed by inverter.
//   a, b in; y = a & b
module gate_and (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n;
  gate_nand u_n (.a(a), .b(b), .y(n));
  gate_not  u_i (.a(n), .y(y));
endmodule

// gate_or -- nand of inverted inputs.
//   a, b in; y = a | b
module gate_or (
  input  logic a,
  input  logic b,
  output logic y
);
  logic a_n;
  logic b_n;
  gate_not  u_a (.a(a), .y(a_n));
  gate_not  u_b (.a(b), .y(b_n));
  gate_nand u_n (.a(a_n), .b(b_n), .y(y));
endmodule

// gate_mux -- 2:1 mux.
//   a, b, sel in; y = sel ? b : a
module gate_mux (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  logic sel_n;
  logic pick_a;
  logic pick_b;
  gate_not u_s  (.a(sel), .y(sel_n));
  gate_and u_a  (.a(a), .b(sel_n), .y(pick_a));
  gate_and u_b  (.a(b), .b(sel), .y(pick_b));
  gate_or  u_or (.a(pick_a), .b(pick_b), .y(y));
endmodule

// gate_half_adder -- four-nand xor for sum, and for carry.
//   a, b in; sum = a ^ b, carry = a & b
module gate_half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  logic n_ab;
  logic n_a;
  logic n_b;
  gate_nand u_n0 (.a(a), .b(b), .y(n_ab));
  gate_nand u_n1 (.a(a), .b(n_ab), .y(n_a));
  gate_nand u_n2 (.a(b), .b(n_ab), .y(n_b));
  gate_nand u_n3 (.a(n_a), .b(n_b), .y(sum));
  gate_not  u_c  (.a(n_ab), .y(carry));
endmodule

// File: tb/tb_pc16.sv
module tb_pc16;

  logic        clk;
  logic        rst;
  logic [15:0] in;
  logic        load;
  logic        inc;
  logic        clr;
  logic [15:0] out;
  logic        wrap;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_out;
  logic        m_wrap;

  pc16 #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .load (load),
    .inc  (inc),
    .clr  (clr),
    .out  (out),
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic l, input logic i, input logic [15:0] d);
    clr  = c;
    load = l;
    inc  = i;
    in   = d;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 16'h0000);
    #2;
    chk("reset_out", out, 16'h0000);
    chk("reset_wrap", {15'd0, wrap}, 16'h0);

    // Clock edges while in reset have no effect.
    drive(0, 1, 1, 16'h5555);
    step();
    chk("rst_ignores_clk", out, 16'h0000);
    rst = 1'b0;

    // Async reset between edges with out = 0x1234.
    drive(0, 1, 0, 16'h1234);
    step();
    chk("load_1234", out, 16'h1234);
    drive(0, 0, 0, 16'h0000);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", out, 16'h0000);
    chk("async_rst_wrap", {15'd0, wrap}, 16'h0);
    #1 rst = 1'b0;

    // Count from zero.
    drive(0, 0, 1, 16'h0000);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("count_out", out, 16'(k));
      chk("count_wrap", {15'd0, wrap}, 16'h0);
    end

    // Wrap from a loaded 0xFFFE.
    drive(0, 1, 0, 16'hFFFE);
    step();
    chk("wrap_load", out, 16'hFFFE);
    drive(0, 0, 1, 16'h0000);
    step();
    chk("wrap_ffff", out, 16'hFFFF);
    chk("wrap_ffff_flag", {15'd0, wrap}, 16'h0);
    step();
    chk("wrap_zero", out, 16'h0000);
    chk("wrap_pulse", {15'd0, wrap}, 16'h1);
    step();
    chk("wrap_one", out, 16'h0001);
    chk("wrap_drop", {15'd0, wrap}, 16'h0);

    // Priority clr > load > inc.
    drive(1, 1, 1, 16'hABCD);
    step();
    chk("prio_clr", out, 16'h0000);
    drive(0, 1, 1, 16'hABCD);
    step();
    chk("prio_load", out, 16'hABCD);
    drive(0, 0, 1, 16'hABCD);
    step();
    chk("prio_inc", out, 16'hABCE);

    // Hold.
    drive(0, 1, 0, 16'h0042);
    step();
    drive(0, 0, 0, 16'h9999);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_out", out, 16'h0042);
      chk("hold_wrap", {15'd0, wrap}, 16'h0);
    end

    // At all-ones, load or clr beats inc and no wrap is flagged.
    drive(0, 1, 0, 16'hFFFF);
    step();
    drive(0, 1, 1, 16'h0005);
    step();
    chk("ffff_load_out", out, 16'h0005);
    chk("ffff_load_wrap", {15'd0, wrap}, 16'h0);
    drive(0, 1, 0, 16'hFFFF);
    step();
    drive(1, 0, 1, 16'h0000);
    step();
    chk("ffff_clr_out", out, 16'h0000);
    chk("ffff_clr_wrap", {15'd0, wrap}, 16'h0);

    // Reset while wrap is high clears it at once.
    drive(0, 1, 0, 16'hFFFF);
    step();
    drive(0, 0, 1, 16'h0000);
    step();
    chk("wrap_again", {15'd0, wrap}, 16'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_kills_wrap", {15'd0, wrap}, 16'h0);
    #1 rst = 1'b0;

    // Reset mid-count: counting restarts from zero.
    drive(0, 1, 0, 16'h7000);
    step();
    drive(0, 0, 1, 16'h0000);
    step();
    chk("midcount_pre", out, 16'h7001);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    step();
    chk("midcount_post", out, 16'h0001);

    // Randomised run against a behavioural reference.
    m_out  = out;
    m_wrap = wrap;
    for (int k = 0; k < 4000; k++) begin
      drive($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
            ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom));
      if ($urandom_range(63) == 0) begin
        #1 rst = 1'b1;
        #1;
        chk("rand_rst_out", out, 16'h0000);
        rst = 1'b0;
        m_out  = 16'h0000;
        m_wrap = 1'b0;
      end
      step();
      if (clr) begin
        m_wrap = 1'b0;
        m_out  = 16'h0000;
      end else if (load) begin
        m_wrap = 1'b0;
        m_out  = in;
      end else if (inc) begin
        m_wrap = (m_out == 16'hFFFF);
        m_out  = m_out + 16'd1;
      end else begin
        m_wrap = 1'b0;
      end
      chk("rand_out", out, m_out);
      chk("rand_wrap", {15'd0, wrap}, {15'd0, m_wrap});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
